// File: rtl/fib_seq_driver_if.sv
// fib_seq_driver_if -- request, Avalon-MM master and response signals of
// fib_seq_driver. The master modport is the driver's view; the slave modport
// is the view of whatever sits around it (upstream, slave and downstream).
interface fib_seq_driver_if #(
    parameter int N_W = 8
);
    // upstream request
    logic           cmd_valid;
    logic           cmd_ready;
    logic [N_W-1:0] cmd_n;

    // Avalon-MM master towards the Fibonacci slave
    logic [1:0]     m_address;
    logic           m_chipselect;
    logic           m_read;
    logic           m_write;
    logic [31:0]    m_writedata;
    logic [31:0]    m_readdata;

    // downstream result
    logic           rsp_valid;
    logic           rsp_ready;
    logic [31:0]    rsp_data;
    logic           rsp_err;

    modport master (
        input  cmd_valid, cmd_n, m_readdata, rsp_ready,
        output cmd_ready, m_address, m_chipselect, m_read, m_write, m_writedata,
               rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        output cmd_valid, cmd_n, m_readdata, rsp_ready,
        input  cmd_ready, m_address, m_chipselect, m_read, m_write, m_writedata,
               rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/fib_seq_driver.sv
// fib_seq_driver -- accepts a Fibonacci index, programs an Avalon-MM
// Fibonacci slave (write N, write start), polls its status register until
// done, reads the result and hands it downstream.
// Slave map: 0 = N, 1 = control (1 = start), 2 = result, 3 = status (bit0 done).
// Optional: define FIB_DRV_TIMEOUT_EN to give up after POLL_MAX+1 not-done
// polls and answer with rsp_err=1, rsp_data=0.
module fib_seq_driver #(
    parameter int N_W      = 8,
    parameter int POLL_MAX = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    fib_seq_driver_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE, WR_N, WR_GO, POLL_RD, POLL_CAP, RES_RD, RES_CAP, RSP
    } state_e;

    localparam logic [1:0] ADDR_N      = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_RESULT = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    // The poll counter is 8 bits wide, so the timeout threshold must fit in it.
    if (POLL_MAX < 0 || POLL_MAX > 255) begin : g_poll_max_range
        $error("fib_seq_driver: POLL_MAX must lie in 0..255");
    end

    state_e      state_q, state_d;
    logic        run_q;       // low in reset, high from the first edge after release
    logic [31:0] n_q;         // latched request, zero-extended
    logic [7:0]  poll_cnt;    // not-done status polls of the current request
    logic [31:0] rsp_data_q;
    logic        accept;
    logic        not_done;

    assign accept   = (state_q == IDLE) && run_q && bus.cmd_valid;
    assign not_done = (state_q == POLL_CAP) && !bus.m_readdata[0];

`ifdef FIB_DRV_TIMEOUT_EN
    localparam logic [7:0] POLL_LIMIT = 8'(POLL_MAX);
    logic rsp_err_q;
    logic timeout;
    assign timeout     = not_done && (poll_cnt == POLL_LIMIT);
    assign bus.rsp_err = rsp_err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.rsp_data = rsp_data_q;

    // State register plus the reset-release flag that gates cmd_ready.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: non-blocking assignments for all registered state, so every
        // flop samples the values from before the edge.
        if (!reset_n) begin
            state_q <= IDLE;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end

    // Next state and bus strobes, decoded from the current state only.
    always_comb begin
        // NOTE: every output gets a default before the case so no latch is
        // inferred and the bus is idle (all zero) in IDLE and RSP.
        state_d          = state_q;
        bus.cmd_ready    = 1'b0;
        bus.m_address    = 2'd0;
        bus.m_chipselect = 1'b0;
        bus.m_read       = 1'b0;
        bus.m_write      = 1'b0;
        bus.m_writedata  = 32'd0;
        bus.rsp_valid    = 1'b0;
        case (state_q)
            IDLE: begin
                bus.cmd_ready = run_q;
                if (accept) state_d = WR_N;
            end
            WR_N: begin
                bus.m_address    = ADDR_N;
                bus.m_chipselect = 1'b1;
                bus.m_write      = 1'b1;
                bus.m_writedata  = n_q;
                state_d          = WR_GO;
            end
            WR_GO: begin
                bus.m_address    = ADDR_CTRL;
                bus.m_chipselect = 1'b1;
                bus.m_write      = 1'b1;
                bus.m_writedata  = 32'd1;
                state_d          = POLL_RD;
            end
            POLL_RD: begin
                bus.m_address    = ADDR_STATUS;
                bus.m_chipselect = 1'b1;
                bus.m_read       = 1'b1;
                state_d          = POLL_CAP;
            end
            POLL_CAP: begin
                bus.m_address    = ADDR_STATUS;
                bus.m_chipselect = 1'b1;
                if (bus.m_readdata[0]) state_d = RES_RD;
`ifdef FIB_DRV_TIMEOUT_EN
                else if (timeout)      state_d = RSP;
`endif
                else                   state_d = POLL_RD;
            end
            RES_RD: begin
                bus.m_address    = ADDR_RESULT;
                bus.m_chipselect = 1'b1;
                bus.m_read       = 1'b1;
                state_d          = RES_CAP;
            end
            RES_CAP: begin
                bus.m_address    = ADDR_RESULT;
                bus.m_chipselect = 1'b1;
                state_d          = RSP;
            end
            RSP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latch, saturating poll counter and the held response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n_q        <= 32'd0;
            poll_cnt   <= 8'd0;
            rsp_data_q <= 32'd0;
`ifdef FIB_DRV_TIMEOUT_EN
            rsp_err_q  <= 1'b0;
`endif
        end else begin
            if (accept) begin
                n_q      <= 32'(bus.cmd_n);
                poll_cnt <= 8'd0;
            end
            if (not_done && poll_cnt != 8'hFF) poll_cnt <= poll_cnt + 8'd1;
            if (state_q == RES_CAP) begin
                rsp_data_q <= bus.m_readdata;
`ifdef FIB_DRV_TIMEOUT_EN
                rsp_err_q  <= 1'b0;
`endif
            end
`ifdef FIB_DRV_TIMEOUT_EN
            if (timeout) begin
                rsp_data_q <= 32'd0;
                rsp_err_q  <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_fib_seq_driver.sv
// tb_fib_seq_driver -- self-checking bench for fib_seq_driver. A behavioural
// Fibonacci slave answers the Avalon-MM bus; results are compared against a
// Fibonacci table built by recurrence and a latency rule derived from the
// poll count (5 + 2*polls cycles from accept to rsp_valid).
module tb_fib_seq_driver;

`ifdef FIB_DRV_TIMEOUT_EN
    localparam int PM = 3;
`else
    localparam int PM = 255;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    fib_seq_driver_if #(.N_W(8)) bus ();

    fib_seq_driver #(.N_W(8), .POLL_MAX(PM)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference Fibonacci table (32-bit wrap) ----------------
    logic [31:0] fib_tab [0:255];
    initial begin
        fib_tab[0] = 32'd0;
        fib_tab[1] = 32'd1;
        for (int i = 2; i < 256; i++) fib_tab[i] = fib_tab[i-1] + fib_tab[i-2];
    end

    // ---------------- behavioural Fibonacci slave ----------------
    logic [31:0] sl_n = 32'd0;
    int          sl_polls = 0;
    int          sl_done_after = 1;   // 0: never done
    logic [33:0] wr_log [$];
    int          status_reads = 0;
    int          result_reads = 0;
    int          proto_viol = 0;

    initial bus.m_readdata = 32'd0;

    always @(posedge clk) begin
        if (bus.m_chipselect && bus.m_write) begin
            wr_log.push_back({bus.m_address, bus.m_writedata});
            if (bus.m_address == 2'd0) sl_n = bus.m_writedata;
            if (bus.m_address == 2'd1 && bus.m_writedata == 32'd1) sl_polls = 0;
        end
        if (bus.m_chipselect && bus.m_read) begin
            if (bus.m_address == 2'd3) begin
                sl_polls++;
                status_reads++;
                bus.m_readdata <= {31'd0, (sl_done_after != 0) && (sl_polls >= sl_done_after)};
            end else if (bus.m_address == 2'd2) begin
                result_reads++;
                bus.m_readdata <= fib_tab[sl_n[7:0]];
            end else begin
                bus.m_readdata <= 32'hDEAD_BEEF;
            end
        end else begin
            bus.m_readdata <= 32'hDEAD_BEEF;
        end
    end

    // bus rules: never read and write together; idle bus is fully zero
    always @(negedge clk) begin
        if ((bus.m_read && bus.m_write) ||
            (!bus.m_chipselect && (bus.m_read || bus.m_write || bus.m_writedata != 32'd0)) ||
            (bus.m_read && bus.m_writedata != 32'd0))
            proto_viol++;
    end

    // ---------------- reference model of one transaction ----------------
    function automatic void model(input logic [7:0] n, input int k,
                                  output logic [31:0] d, output logic e,
                                  output int lat, output int polls, output int res);
`ifdef FIB_DRV_TIMEOUT_EN
        if (k == 0 || k > PM + 1) begin
            d = 32'd0; e = 1'b1; polls = PM + 1; lat = 3 + 2 * polls; res = 0;
            return;
        end
`endif
        d = fib_tab[n]; e = 1'b0; polls = k; lat = 5 + 2 * k; res = 1;
    endfunction

    // One full request; called at a negedge with the DUT in IDLE.
    // hold < 0 keeps rsp_ready high throughout, otherwise rsp_ready stays low
    // for 'hold' cycles of rsp_valid.
    task automatic run_txn(input string name, input logic [7:0] n, input int k, input int hold,
                           input logic [31:0] exp_data, input logic exp_err, input int exp_lat,
                           input int exp_polls, input int exp_res, input bit busy_pulse);
        int          lat;
        logic [31:0] first_data;
        bit          stable;
        bit          busy_ready_seen;
        int          wr_before;
        int          rd_before;
        logic [67:0] wr_act;
        sl_done_after = k;
        wr_log.delete();
        status_reads = 0;
        result_reads = 0;
        busy_ready_seen = 1'b0;
        bus.rsp_ready = (hold < 0);
        bus.cmd_n     = n;
        bus.cmd_valid = 1'b1;
        check({name, " cmd_ready idle"}, bus.cmd_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_n     = 8'd0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (bus.cmd_ready) busy_ready_seen = 1'b1;
            if (busy_pulse && lat == 3) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_n     = 8'd80;
            end
            if (busy_pulse && lat == 6) bus.cmd_valid = 1'b0;
        end while (!bus.rsp_valid && lat < 600);
        bus.cmd_valid = 1'b0;
        check({name, " latency"}, lat, exp_lat);
        check({name, " cmd_ready busy"}, busy_ready_seen, 1'b0);
        check({name, " rsp_data"}, bus.rsp_data, exp_data);
        check({name, " rsp_err"}, bus.rsp_err, exp_err);
        first_data = bus.rsp_data;
        wr_before  = wr_log.size();
        rd_before  = status_reads + result_reads;
        stable     = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!bus.rsp_valid || bus.rsp_data !== first_data || bus.rsp_err !== exp_err) stable = 1'b0;
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check({name, " rsp stable"}, stable, 1'b1);
        check({name, " rsp_valid dropped"}, bus.rsp_valid, 1'b0);
        check({name, " back to idle"}, bus.cmd_ready, 1'b1);
        check({name, " bus quiet in rsp"}, (wr_log.size() == wr_before) &&
              (status_reads + result_reads == rd_before), 1'b1);
        wr_act = (wr_log.size() == 2) ? {wr_log[0], wr_log[1]} : 68'd0;
        check({name, " writes"}, wr_act, {2'd0, 24'd0, n, 2'd1, 32'd1});
        check({name, " status polls"}, status_reads, exp_polls);
        check({name, " result reads"}, result_reads, exp_res);
        if (busy_pulse) begin
            repeat (8) @(negedge clk);
            check({name, " busy cmd ignored"}, wr_log.size(), 2);
        end
    endtask

    typedef struct {
        logic [7:0]  n;
        int          k;
        int          hold;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [31:0] md;
        logic        me;
        int          ml, mp, mr;
        int          seen;
        int          wait_cnt;

        vecs[0] = '{8'd21, 1,  0, 32'd10946,     7};
        vecs[1] = '{8'd0,  1,  0, 32'd0,         7};
        vecs[2] = '{8'd1,  2,  1, 32'd1,         9};
        vecs[3] = '{8'd7,  1, -1, 32'd13,        7};
        vecs[4] = '{8'd12, 4,  2, 32'd144,       13};
        vecs[5] = '{8'd47, 3,  0, 32'hB11924E1,  11};
        vecs[6] = '{8'd48, 1,  0, 32'd512559680, 7};

        bus.cmd_valid = 1'b0;
        bus.cmd_n     = 8'd0;
        bus.rsp_ready = 1'b0;

        // reset: everything zero while held, cmd_ready only after first edge
        repeat (10) @(negedge clk);
        check("reset outputs", {bus.cmd_ready, bus.m_address, bus.m_chipselect, bus.m_read,
              bus.m_write, bus.m_writedata, bus.rsp_valid, bus.rsp_data, bus.rsp_err}, 0);
        reset_n = 1'b1;
        #1;
        check("cmd_ready before first edge", bus.cmd_ready, 1'b0);
        @(negedge clk);
        check("cmd_ready after release", bus.cmd_ready, 1'b1);

        // table-driven transactions
        for (int i = 0; i < 7; i++)
            run_txn($sformatf("vec%0d", i), vecs[i].n, vecs[i].k, vecs[i].hold,
                    vecs[i].exp_data, 1'b0, vecs[i].exp_lat, vecs[i].k, 1, 1'b0);

        // five polls, rsp_ready held low four cycles
        model(8'd40, 5, md, me, ml, mp, mr);
        run_txn("n40 five polls", 8'd40, 5, 4, md, me, ml, mp, mr, 1'b0);

        // request presented while busy must be dropped
        model(8'd10, 2, md, me, ml, mp, mr);
        run_txn("busy pulse", 8'd10, 2, 0, md, me, ml, mp, mr, 1'b1);

        // randomized requests against the model
        for (int r = 0; r < 20; r++) begin
            logic [7:0] rn;
            int         rk, rh;
            rn = 8'($urandom_range(0, 255));
            rk = int'($urandom_range(1, 4));
            rh = int'($urandom_range(0, 4)) - 1;
            model(rn, rk, md, me, ml, mp, mr);
            run_txn($sformatf("rand%0d n=%0d", r, rn), rn, rk, rh, md, me, ml, mp, mr, 1'b0);
        end

`ifdef FIB_DRV_TIMEOUT_EN
        // done never set: give up after PM+1 polls
        model(8'd9, 0, md, me, ml, mp, mr);
        run_txn("timeout", 8'd9, 0, 0, md, me, ml, mp, mr, 1'b0);
`endif

        // done never set, reset lands in POLL_RD
        sl_done_after = 0;
        status_reads  = 0;
        bus.cmd_n     = 8'd30;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
`ifndef FIB_DRV_TIMEOUT_EN
        seen = 0;
        repeat (110) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        check("no timeout rsp_valid", seen, 0);
        check("polling continues", status_reads >= 50, 1'b1);
`endif
        wait_cnt = 0;
        do begin
            @(negedge clk);
            wait_cnt++;
        end while (!(bus.m_read && bus.m_address == 2'd3) && wait_cnt < 40);
        check("reached POLL_RD", bus.m_read && bus.m_address == 2'd3, 1'b1);
        reset_n = 1'b0;
        #1;
        check("strobes drop in reset", {bus.m_chipselect, bus.m_read, bus.m_write,
              bus.m_address, bus.m_writedata}, 0);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.rsp_valid || bus.cmd_ready) seen++;
        end
        check("quiet while in reset", seen, 0);
        reset_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        run_txn("after reset n7", 8'd7, 1, 0, 32'd13, 1'b0, 7, 1, 1, 1'b0);

        check("bus protocol", proto_viol, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
